// File: rtl/alu_muldiv.sv
// ---------------------------------------------------------------------------
// alu_muldiv - handshaked EX-stage execute unit.
//
// Performs the RV32I ALU operations (including the LUI pass-through) with a
// registered result. It also performs the RV32M multiply/divide operations on
// an iterative radix-2 datapath: one shift-add or one restoring shift-subtract
// per cycle, taking XLEN cycles in BUSY.
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     synchronous active-low reset
//   i_valid     request valid          o_ready     request accepted (IDLE)
//   i_alu_op    bit4=0: base op [3:0]; bit4=1: M op, funct3 in [2:0]
//   i_op_a      operand A / rs1        i_op_b      operand B / rs2 / imm
//   o_valid     result valid, held until i_ready
//   i_ready     downstream accepts the result
//   o_alu_data  result
//
// Build option:
//   ALU_MULDIV_FAST_MUL_EN - when defined, the four multiplies use a single
//   combinational 2*XLEN multiplier with latency 1. Division stays iterative.
// ---------------------------------------------------------------------------
module alu_muldiv #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [4:0]      i_alu_op,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_alu_data
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_reg;
    logic [SHW-1:0]    count_reg;
    logic [2:0]        funct3_reg;
    logic              neg_reg;      // negate product, or negate quotient
    logic              rem_neg_reg;  // remainder follows the dividend sign
    logic [2*XLEN-1:0] acc_reg;      // product, or {remainder, quotient}
    logic [XLEN-1:0]   opnd_reg;     // multiplicand or divisor magnitude

    assign o_ready = (state_reg == IDLE);

    // ---------------- request decode ----------------
    logic            is_m, is_div, sgn_a, sgn_b, a_neg, b_neg, div_special;
    logic [XLEN-1:0] mag_a, mag_b, base_res, special_res, fast_res;
    logic            fast_path;

    assign is_m   = i_alu_op[4];
    assign is_div = i_alu_op[4] & i_alu_op[2];
    // A is signed for MULH, MULHSU, DIV, REM; B for MULH, DIV, REM.
    assign sgn_a  = (i_alu_op[2:0] == 3'b001) | (i_alu_op[2:0] == 3'b010) |
                    (i_alu_op[2] & ~i_alu_op[0]);
    assign sgn_b  = (i_alu_op[2:0] == 3'b001) | (i_alu_op[2] & ~i_alu_op[0]);
    assign a_neg  = sgn_a & i_op_a[XLEN-1];
    assign b_neg  = sgn_b & i_op_b[XLEN-1];
    assign mag_a  = a_neg ? -i_op_a : i_op_a;
    assign mag_b  = b_neg ? -i_op_b : i_op_b;

    assign div_special = is_div & ((i_op_b == '0) |
                         (sgn_a & (i_op_a == MIN_INT) & (i_op_b == '1)));

    always_comb begin
        if (i_op_b == '0)
            special_res = i_alu_op[1] ? i_op_a : '1;
        else
            special_res = i_alu_op[1] ? '0 : MIN_INT;
    end

    always_comb begin
        base_res = '0;
        case (i_alu_op[3:0])
            4'b0000: base_res = i_op_a + i_op_b;
            4'b1000: base_res = i_op_a - i_op_b;
            4'b0001: base_res = i_op_a << i_op_b[SHW-1:0];
            4'b0010: base_res[0] = $signed(i_op_a) < $signed(i_op_b);
            4'b0011: base_res[0] = i_op_a < i_op_b;
            4'b0100: base_res = i_op_a ^ i_op_b;
            4'b0101: base_res = i_op_a >> i_op_b[SHW-1:0];
            4'b1101: base_res = $signed(i_op_a) >>> i_op_b[SHW-1:0];
            4'b0110: base_res = i_op_a | i_op_b;
            4'b0111: base_res = i_op_a & i_op_b;
            4'b1111: base_res = i_op_b;
            default: base_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    // Sign-extending to 2*XLEN makes one unsigned multiplier serve all four.
    assign fast_prod = {{XLEN{a_neg}}, i_op_a} * {{XLEN{b_neg}}, i_op_b};
    assign fast_path = ~is_m | div_special | ~i_alu_op[2];
    always_comb begin
        if (!is_m)
            fast_res = base_res;
        else if (!i_alu_op[2])
            fast_res = (i_alu_op[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                                : fast_prod[2*XLEN-1:XLEN];
        else
            fast_res = special_res;
    end
`else
    assign fast_path = ~is_m | div_special;
    assign fast_res  = is_m ? special_res : base_res;
`endif

    // ---------------- iterative step ----------------
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
    logic [XLEN-1:0]   mul_res, div_res, busy_res, quo, rem;

    always_comb begin
        // Shift-add: multiplier bits are consumed from the low half.
        mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                   (acc_reg[0] ? {1'b0, opnd_reg} : '0);
        mul_next = {mul_sum, acc_reg[XLEN-1:1]};
        // Restoring divide: a set top bit of the difference means "no fit".
        div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_reg};
        if (!div_diff[XLEN])
            div_next = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
        else
            div_next = {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
        // Sign correction applied to the last step's value.
        prod_fix = neg_reg ? -mul_next : mul_next;
        mul_res  = (funct3_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                              : prod_fix[2*XLEN-1:XLEN];
        quo      = div_next[XLEN-1:0];
        rem      = div_next[2*XLEN-1:XLEN];
        if (funct3_reg[1])
            div_res = rem_neg_reg ? -rem : rem;
        else
            div_res = neg_reg ? -quo : quo;
        busy_res = funct3_reg[2] ? div_res : mul_res;
    end

    // ---------------- control and state ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg   <= IDLE;
            o_valid     <= 1'b0;
            o_alu_data  <= '0;
            count_reg   <= '0;
            funct3_reg  <= '0;
            neg_reg     <= 1'b0;
            rem_neg_reg <= 1'b0;
            acc_reg     <= '0;
            opnd_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_valid) begin
                        if (fast_path) begin
                            o_alu_data <= fast_res;
                            o_valid    <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            funct3_reg  <= i_alu_op[2:0];
                            neg_reg     <= a_neg ^ b_neg;
                            rem_neg_reg <= a_neg;
                            count_reg   <= SHW'(XLEN-1);
                            state_reg   <= BUSY;
                            if (i_alu_op[2]) begin
                                acc_reg  <= {{XLEN{1'b0}}, mag_a};
                                opnd_reg <= mag_b;
                            end else begin
                                acc_reg  <= {{XLEN{1'b0}}, mag_b};
                                opnd_reg <= mag_a;
                            end
                        end
                    end
                end
                BUSY: begin
                    acc_reg   <= funct3_reg[2] ? div_next : mul_next;
                    count_reg <= count_reg - SHW'(1);
                    if (count_reg == '0) begin
                        o_alu_data <= busy_res;
                        o_valid    <= 1'b1;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid   <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv - self-checking bench for alu_muldiv (XLEN=32).
// Directed steps followed by randomized requests; expectations come from
// a plain-arithmetic reference model of the operation set.
// ---------------------------------------------------------------------------
module tb_alu_muldiv;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [4:0]  i_alu_op = '0;
    logic [31:0] i_op_a = '0;
    logic [31:0] i_op_b = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_alu_data;

    int n_checks = 0;
    int n_fail   = 0;

    alu_muldiv #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_alu_op(i_alu_op), .i_op_a(i_op_a), .i_op_b(i_op_b),
        .o_valid(o_valid), .i_ready(i_ready), .o_alu_data(o_alu_data)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: RV32I/RV32M results from ordinary integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [4:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        int              sa, sb;
        longint          p;
        longint unsigned pu;
        int unsigned     sh;
        sa = a;
        sb = b;
        sh = {27'd0, b[4:0]};
        if (!op[4]) begin
            case (op[3:0])
                4'b0000: return a + b;
                4'b1000: return a - b;
                4'b0001: return a << sh;
                4'b0010: return (sa < sb) ? 32'd1 : 32'd0;
                4'b0011: return (a < b) ? 32'd1 : 32'd0;
                4'b0100: return a ^ b;
                4'b0101: return a >> sh;
                4'b1101: return 32'(sa >>> sh);
                4'b0110: return a | b;
                4'b0111: return a & b;
                4'b1111: return b;
                default: return 32'd0;
            endcase
        end
        case (op[2:0])
            3'b000: begin pu = 64'(a) * 64'(b); return pu[31:0]; end
            3'b001: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'b010: begin p = longint'(sa) * longint'(64'(b)); return p[63:32]; end
            3'b011: begin pu = 64'(a) * 64'(b); return pu[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Cycles from the accept edge until o_valid is seen.
    function automatic int ref_lat(input logic [4:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        if (!op[4]) return 1;
        if (!op[2]) begin
`ifdef ALU_MULDIV_FAST_MUL_EN
            return 1;
`else
            return 33;
`endif
        end
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issues one request from IDLE (called #1 after a rising edge), waits for
    // the result, checks value/latency/ready, then hands it off.
    task automatic run_op(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int          exp_lat, lat, bad_ready;
        exp     = ref_model(op, a, b);
        exp_lat = ref_lat(op, a, b);
        i_valid = 1'b1; i_alu_op = op; i_op_a = a; i_op_b = b;
        @(posedge i_clk); #1;
        i_valid  = 1'b0;
        i_alu_op = 5'($urandom);
        i_op_a   = $urandom;
        i_op_b   = $urandom;
        lat = 1;
        bad_ready = 0;
        while (o_valid !== 1'b1 && lat < 100) begin
            if (o_ready !== 1'b0) bad_ready++;
            @(posedge i_clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, o_alu_data, exp);
        chk({tag, "_busy_ready"}, 32'(bad_ready), 32'd0);
        chk({tag, "_done_ready"}, {31'd0, o_ready}, 32'd0);
        $display("op=%b a=%h b=%h -> %h (exp %h) latency %0d", op, a, b, o_alu_data, exp, lat);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, o_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        logic [4:0]  rop;
        logic [31:0] ra, rb, held;
        int          stale;

        // Reset
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_data", o_alu_data, 32'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Base ops
        run_op("add", 5'b00000, 32'd5, 32'd7);
        run_op("slt", 5'b00010, 32'hFFFF_FFFF, 32'd1);
        run_op("sltu", 5'b00011, 32'hFFFF_FFFF, 32'd1);
        run_op("sra", 5'b01101, 32'h8000_0000, 32'd4);
        run_op("lui", 5'b01111, 32'hDEAD_BEEF, 32'h1234_5000);
        run_op("sub", 5'b01000, 32'd3, 32'd10);
        run_op("unused", 5'b01010, 32'h55, 32'h66);

        // Multiplies
        run_op("mulh", 5'b10001, 32'h8000_0000, 32'h8000_0000);
        run_op("mulhu", 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mul", 5'b10000, 32'hFFFF_FFFD, 32'd7);
        run_op("mulhsu", 5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Divides, including the fast special cases
        run_op("div", 5'b10100, 32'hFFFF_FFF9, 32'd2);
        run_op("rem", 5'b10110, 32'hFFFF_FFF9, 32'd2);
        run_op("divu0", 5'b10101, 32'd7, 32'd0);
        run_op("remu0", 5'b10111, 32'd7, 32'd0);
        run_op("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF);

        // Backpressure: result held in DONE, new requests ignored
        i_valid = 1'b1; i_alu_op = 5'b00100; i_op_a = 32'hF0F0_1234; i_op_b = 32'h0FF0_4321;
        held = ref_model(5'b00100, 32'hF0F0_1234, 32'h0FF0_4321);
        @(posedge i_clk); #1;
        i_alu_op = 5'b00000; i_op_a = 32'd1; i_op_b = 32'd1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {31'd0, o_valid}, 32'd1);
            chk("bp_data", o_alu_data, held);
            chk("bp_ready", {31'd0, o_ready}, 32'd0);
            $display("backpressure cycle %0d: valid=%b data=%h ready=%b", k, o_valid, o_alu_data, o_ready);
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        chk("bp_release_valid", {31'd0, o_valid}, 32'd0);
        @(posedge i_clk); #1;
        chk("bp_no_ghost", {31'd0, o_valid}, 32'd0);

        // Reset in the middle of a DIVU
        i_valid = 1'b1; i_alu_op = 5'b10101; i_op_a = 32'd1000; i_op_b = 32'd7;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (9) @(posedge i_clk);
        #1;
        chk("midrst_busy_ready", {31'd0, o_ready}, 32'd0);
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        chk("midrst_valid", {31'd0, o_valid}, 32'd0);
        chk("midrst_data", o_alu_data, 32'd0);
        chk("midrst_ready", {31'd0, o_ready}, 32'd1);
        stale = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_valid !== 1'b0) stale++;
            @(posedge i_clk); #1;
        end
        chk("midrst_no_stale", 32'(stale), 32'd0);
        $display("mid-busy reset: stale results seen = %0d", stale);

        // Randomized requests
        for (int n = 0; n < 40; n++) begin
            rop = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 5))
                0: ra = 32'd0;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op("rand", rop, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
